// File: rtl/ddr_capture_ctrl_pkg.sv
// Shared types and sizing helpers for the DDR capture sequencer.
// Optional feature macro: DDR_CAPTURE_OVF_CNT_EN (adds the saturating ovf_cnt output).
package ddr_capture_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam int DDR_DW_DEF         = 8;
  localparam int DDR_SYNC_COUNT_DEF = 2;
  localparam int DDR_OVF_CNT_W      = 16;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int ddr_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ddr_word_aligner.sv
// Bit-level front end: shift register over the DDR pair, word phase counter,
// slip selection between the two candidate windows and sync-word match flags.
module ddr_word_aligner
  import ddr_capture_pkg::*;
#(
  parameter int                    DATA_WIDTH = DDR_DW_DEF,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = DATA_WIDTH'(8'hA5)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_shift,
  input  logic [1:0]            i_ddr,
  input  logic                  i_load,
  input  logic                  i_load_slip,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_match0,
  output logic                  o_match1,
  output logic                  o_boundary
);

  localparam int            N       = DATA_WIDTH / 2;
  localparam int            PW      = ddr_cnt_w(N);
  localparam logic [PW-1:0] PH_LAST = PW'(N - 1);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);

  logic [DATA_WIDTH:0]   r_shreg;
  logic [PW-1:0]         r_phase;
  logic                  r_slip;
  logic [DATA_WIDTH-1:0] w_win0;
  logic [DATA_WIDTH-1:0] w_win1;

  // A load marks the current cycle as a word boundary, so the next one is N shifts later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_phase <= '0;
      r_slip  <= 1'b0;
    end else begin
      if (i_shift) begin
        r_shreg <= {r_shreg[DATA_WIDTH-2:0], i_ddr};
      end
      if (i_load) begin
        r_phase <= PH_ONE;
        r_slip  <= i_load_slip;
      end else if (i_shift) begin
        r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
      end
    end
  end

  assign w_win0     = r_shreg[DATA_WIDTH-1:0];
  assign w_win1     = r_shreg[DATA_WIDTH:1];
  assign o_match0   = (w_win0 == SYNC_WORD);
  assign o_match1   = (w_win1 == SYNC_WORD);
  assign o_word     = r_slip ? w_win1 : w_win0;
  assign o_boundary = i_shift && (r_phase == '0);

endmodule

// File: rtl/ddr_capture_ctrl.sv
// Sync-word hunt / verify / lock sequencer with a one-deep valid/ready output register.
// Optional feature macro: DDR_CAPTURE_OVF_CNT_EN (adds ovf_cnt, a saturating dropped-word count).
module ddr_capture_ctrl
  import ddr_capture_pkg::*;
#(
  parameter int                    DATA_WIDTH = DDR_DW_DEF,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = DATA_WIDTH'(8'hA5),
  parameter int                    SYNC_COUNT = DDR_SYNC_COUNT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            ddr_in,
  input  logic                  realign,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  locked,
  output logic                  ovf,
  input  logic                  ovf_clr
`ifdef DDR_CAPTURE_OVF_CNT_EN
  ,
  output logic [DDR_OVF_CNT_W-1:0] ovf_cnt
`endif
);

  localparam int            VW        = ddr_cnt_w(SYNC_COUNT + 1);
  localparam logic [VW-1:0] VCNT_LAST = VW'(SYNC_COUNT - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [VW-1:0]         r_vcnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_ovf;

  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_match0;
  logic                  w_match1;
  logic                  w_boundary;
  logic                  w_word_match;
  logic                  w_search_hit;
  logic                  w_lock_hit;
  logic                  w_deliver;
  logic                  w_locked;
  logic                  w_drop;

  ddr_word_aligner #(
    .DATA_WIDTH (DATA_WIDTH),
    .SYNC_WORD  (SYNC_WORD)
  ) u_align (
    .clk         (clk),
    .rst         (rst),
    .i_shift     (en),
    .i_ddr       (ddr_in),
    .i_load      (w_search_hit),
    .i_load_slip (!w_match0),
    .o_word      (w_word),
    .o_match0    (w_match0),
    .o_match1    (w_match1),
    .o_boundary  (w_boundary)
  );

  assign w_word_match = (w_word == SYNC_WORD);
  assign w_search_hit = (r_state == SEARCH) && en && !realign && (w_match0 || w_match1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = IDLE;
    end else if (realign) begin
      w_state_nxt = SEARCH;
    end else begin
      case (r_state)
        IDLE:   w_state_nxt = SEARCH;
        SEARCH: if (w_match0 || w_match1) w_state_nxt = VERIFY;
        VERIFY: begin
          if (w_boundary) begin
            if (!w_word_match)              w_state_nxt = SEARCH;
            else if (r_vcnt == VCNT_LAST)   w_state_nxt = LOCKED;
          end
        end
        LOCKED: w_state_nxt = LOCKED;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // The boundary that completes verification also hands its sync word downstream.
  always_comb begin
    w_locked   = (r_state == LOCKED);
    w_lock_hit = (r_state == VERIFY) && w_boundary && w_word_match && (r_vcnt == VCNT_LAST);
    w_deliver  = 1'b0;
    if (en && !realign && w_boundary) begin
      w_deliver = (r_state == LOCKED) || w_lock_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vcnt <= '0;
    end else if ((r_state != VERIFY) || (w_state_nxt != VERIFY)) begin
      r_vcnt <= '0;
    end else if (w_boundary) begin
      r_vcnt <= r_vcnt + 1'b1;
    end
  end

  assign w_drop = w_deliver && r_valid && !m_ready;

  // A completing word may replace the pending one only when it is being accepted this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_deliver && (!r_valid || m_ready)) begin
      r_data  <= w_word;
      r_valid <= 1'b1;
    end else if (r_valid && m_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef DDR_CAPTURE_OVF_CNT_EN
  logic [DDR_OVF_CNT_W-1:0] r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_cnt <= '0;
    end else if (w_drop) begin
      if (ovf_clr)               r_ovf_cnt <= DDR_OVF_CNT_W'(1);
      else if (r_ovf_cnt != '1)  r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end else if (ovf_clr) begin
      r_ovf_cnt <= '0;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

  assign m_data  = r_data;
  assign m_valid = r_valid;
  assign locked  = w_locked;
  assign ovf     = r_ovf;

endmodule
